dmem_dump_streamer: RTL

- Hardware counterpart of the bench-side end-of-program memory dump.
- After the pipelined CPU raises end_program, walks NUM_WORDS consecutive data-memory words through a second synchronous read port.
- Emits each word on a valid/ready stream with its index and a last flag, then reports a running 32-bit additive checksum.
- Lets the CPU output its data memory over a host link or trace FIFO without simulator-only memory dump tasks.

---
 rtl/dmem_dump_streamer.sv | 93 +++++++++
 1 files changed

// File: rtl/dmem_dump_streamer.sv
// Streams NUM_WORDS data-memory words over valid/ready after end_program,
// then holds a modulo-2^32 additive checksum of everything accepted.
module dmem_dump_streamer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAP, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word32;

  // Checksum accumulates the low 32 bits of each word (zero-extended if narrower).
  if (DATA_WIDTH >= 32) begin : g_wide
    assign word32 = out_data[31:0];
  end else begin : g_narrow
    assign word32 = {{(32 - DATA_WIDTH){1'b0}}, out_data};
  end

  // Strobes are pure decodes of the state register, so reset clears them at once.
  assign mem_rd_en = (state == S_REQ);
  assign mem_addr  = BASE + idx;
  assign busy      = (state == S_REQ) || (state == S_CAP) || (state == S_SEND);
  assign done      = (state == S_DONE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      checksum  <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx      <= '0;
            checksum <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: state <= S_CAP;
        S_CAP: begin
          out_data  <= mem_rdata;
          out_index <= idx;
          out_last  <= (idx == LAST_IDX);
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          // Word is held here under backpressure; memory is not re-read.
          if (out_ready) begin
            checksum  <= checksum + word32;
            out_valid <= 1'b0;
            if (out_last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + ADDR_WIDTH'(1);
              state <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
